mcs4_rom_arb: RTL and testbench

MCS4_ROM_ARB -- requirements
Module: mcs4_rom_arb

---
 rtl/mcs4_rom_arb.sv | 156 +++++++++++++++
 tb/tb_mcs4_rom_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_rom_arb.sv
// MCS-4 ROM emulation: CPU nibble-bus fetch plus host program-load arbitration on one BRAM port.
// Define MCS4_ROM_TRACE_EN to add the fetch_addr/fetch_count trace outputs.
module mcs4_rom_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync,
  input  logic        cm_rom,
  input  logic [3:0]  dbus_in,
  output logic [3:0]  dbus_out,
  output logic        dbus_oe,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        host_valid,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_data,
  output logic        host_ready,
  output logic [2:0]  phase,
  output logic        locked,
`ifdef MCS4_ROM_TRACE_EN
  output logic [11:0] fetch_addr,
  output logic [15:0] fetch_count,
`endif
  output logic        sync_err
);

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X3 = 3'd7;

  logic        locked_q, locked_d;
  logic [2:0]  phase_q, phase_d;
  logic        sync_err_q, sync_err_d;
  logic [3:0]  addr_lo_q, addr_lo_d;
  logic [3:0]  addr_md_q, addr_md_d;
  logic [7:0]  opc_q, opc_d;
  logic        hit_q, hit_d;
  logic        cpu_rd;
  logic        host_wr;
  logic [11:0] cpu_addr;
`ifdef MCS4_ROM_TRACE_EN
  logic [11:0] faddr_q, faddr_d;
  logic [15:0] fcnt_q, fcnt_d;
`endif

  assign cpu_addr = {dbus_in, addr_md_q, addr_lo_q};
  assign cpu_rd   = !rst && locked_q
                    && (phase_q == PH_A3) && cm_rom;

  // A3 and M1 belong to the CPU: read issue and read return
  assign host_ready = !rst && (!locked_q
                      || ((phase_q != PH_A3)
                      && (phase_q != PH_M1)));
  assign host_wr = host_valid && host_ready;

  always_comb begin
    mem_en    = cpu_rd || host_wr;
    mem_we    = host_wr;
    mem_addr  = host_wr ? host_addr : cpu_addr;
    mem_wdata = host_wr ? host_data : 8'h00;
  end

  always_comb begin
    dbus_oe  = 1'b0;
    dbus_out = 4'h0;
    if (locked_q && hit_q) begin
      if (phase_q == PH_M1) begin
        dbus_oe  = 1'b1;
        dbus_out = mem_rdata[7:4];
      end else if (phase_q == PH_M2) begin
        dbus_oe  = 1'b1;
        dbus_out = opc_q[3:0];
      end
    end
  end

  always_comb begin
    locked_d   = locked_q;
    phase_d    = phase_q;
    sync_err_d = sync_err_q;
    addr_lo_d  = addr_lo_q;
    addr_md_d  = addr_md_q;
    opc_d      = opc_q;
    hit_d      = hit_q;
    if (sync) begin
      locked_d = 1'b1;
      phase_d  = PH_A1;
      if (locked_q && (phase_q != PH_X3))
        sync_err_d = 1'b1;
    end else if (locked_q) begin
      phase_d = phase_q + 3'd1;
    end
    if (locked_q) begin
      if (phase_q == PH_A1) addr_lo_d = dbus_in;
      if (phase_q == PH_A2) addr_md_d = dbus_in;
      if (phase_q == PH_A3) hit_d = cpu_rd;
      // latch here so an M2 host write cannot disturb the M2 nibble
      if (phase_q == PH_M1 && hit_q)
        opc_d = mem_rdata;
    end
  end

`ifdef MCS4_ROM_TRACE_EN
  always_comb begin
    faddr_d = faddr_q;
    fcnt_d  = fcnt_q;
    if (cpu_rd) begin
      faddr_d = cpu_addr;
      fcnt_d  = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      faddr_q <= 12'h000;
      fcnt_q  <= 16'h0000;
    end else begin
      faddr_q <= faddr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign fetch_addr  = faddr_q;
  assign fetch_count = fcnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q   <= 1'b0;
      phase_q    <= PH_A1;
      sync_err_q <= 1'b0;
      addr_lo_q  <= 4'h0;
      addr_md_q  <= 4'h0;
      opc_q      <= 8'h00;
      hit_q      <= 1'b0;
    end else begin
      locked_q   <= locked_d;
      phase_q    <= phase_d;
      sync_err_q <= sync_err_d;
      addr_lo_q  <= addr_lo_d;
      addr_md_q  <= addr_md_d;
      opc_q      <= opc_d;
      hit_q      <= hit_d;
    end
  end

  assign phase    = phase_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_mcs4_rom_arb.sv
// Directed bench for mcs4_rom_arb with a behavioural single-port BRAM.
// Trace checks are compiled in when MCS4_ROM_TRACE_EN is defined.
module tb_mcs4_rom_arb;
  logic        clk = 1'b0;
  logic        rst, sync, cm_rom;
  logic [3:0]  dbus_in, dbus_out;
  logic        dbus_oe, mem_en, mem_we;
  logic [11:0] mem_addr, host_addr;
  logic [7:0]  mem_wdata, mem_rdata, host_data;
  logic        host_valid, host_ready;
  logic [2:0]  phase;
  logic        locked, sync_err;
`ifdef MCS4_ROM_TRACE_EN
  logic [11:0] fetch_addr;
  logic [15:0] fetch_count;
`endif

  logic [7:0] mem [0:4095];
  int checks = 0;
  int errors = 0;
  int seen;

  always #5 clk = ~clk;

  mcs4_rom_arb dut (
    .clk(clk), .rst(rst), .sync(sync),
    .cm_rom(cm_rom), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .dbus_oe(dbus_oe),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .host_valid(host_valid),
    .host_addr(host_addr),
    .host_data(host_data),
    .host_ready(host_ready),
    .phase(phase), .locked(locked),
`ifdef MCS4_ROM_TRACE_EN
    .fetch_addr(fetch_addr),
    .fetch_count(fetch_count),
`endif
    .sync_err(sync_err)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [11:0] a,
                         input logic [7:0] d);
    host_valid = 1'b1;
    host_addr  = a;
    host_data  = d;
    #1;
    chk("load_rdy", host_ready, 1);
    chk("load_we", mem_we, 1);
    tick;
    host_valid = 1'b0;
  endtask

  task automatic lock;
    sync = 1'b1;
    tick;
    sync = 1'b0;
    #1;
    chk("lock", locked, 1);
    chk("lock_ph", phase, 0);
  endtask

  // one full instruction cycle starting in A1, ending back in A1
  task automatic fetch(input logic [11:0] a,
                       input logic cm,
                       input logic hv,
                       input logic [7:0] exp);
    logic [3:0] hi, lo;
    hi = cm ? exp[7:4] : 4'h0;
    lo = cm ? exp[3:0] : 4'h0;
    chk("a1_ph", phase, 0);
    chk("a1_oe", dbus_oe, 0);
    dbus_in = a[3:0];
    tick;
    dbus_in = a[7:4];
    tick;
    dbus_in = a[11:8];
    cm_rom = cm;
    if (hv) begin
      host_valid = 1'b1;
      host_addr  = 12'h123;
      host_data  = 8'h3C;
    end
    #1;
    chk("a3_en", mem_en, cm);
    chk("a3_we", mem_we, 0);
    chk("a3_rdy", host_ready, 0);
    if (cm) chk("a3_addr", mem_addr, a);
    tick;
    cm_rom = 1'b0;
    dbus_in = 4'h0;
    #1;
    chk("m1_oe", dbus_oe, cm);
    chk("m1_out", dbus_out, hi);
    if (hv) chk("m1_rdy", host_ready, 0);
    tick;
    #1;
    chk("m2_oe", dbus_oe, cm);
    chk("m2_out", dbus_out, lo);
    if (hv) begin
      chk("m2_rdy", host_ready, 1);
      chk("m2_we", mem_we, 1);
      chk("m2_addr", mem_addr, 12'h123);
    end
    tick;
    host_valid = 1'b0;
    #1;
    chk("x1_oe", dbus_oe, 0);
    tick;
    tick;
    chk("x3_ph", phase, 7);
    sync = 1'b1;
    tick;
    sync = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    rst = 1'b1;
    sync = 1'b1;
    cm_rom = 1'b0;
    dbus_in = 4'h0;
    host_valid = 1'b1;
    host_addr = 12'h200;
    host_data = 8'h77;
    #1;
    chk("rst_rdy", host_ready, 0);
    chk("rst_en", mem_en, 0);
    tick;
    rst = 1'b0;
    sync = 1'b0;
    host_valid = 1'b0;
    #1;
    chk("rst_lock", locked, 0);
    chk("rst_ph", phase, 0);
    chk("rst_oe", dbus_oe, 0);
    chk("rst_out", dbus_out, 0);
    chk("rst_err", sync_err, 0);
    chk("rst_en2", mem_en, 0);
    chk("unl_rdy", host_ready, 1);
    chk("rst_nowr", mem[12'h200], 8'h00);
`ifdef MCS4_ROM_TRACE_EN
    chk("rst_cnt", fetch_count, 0);
    chk("rst_fa", fetch_addr, 0);
`endif

    host_wr(12'h123, 8'hA5);
    host_wr(12'h000, 8'h5A);
    host_wr(12'h001, 8'hC3);
    host_wr(12'hFFF, 8'h96);
    tick;
    chk("unl_ph", phase, 0);
    chk("unl_lock", locked, 0);

    lock();
    fetch(12'h123, 1'b1, 1'b0, 8'hA5);
    fetch(12'h123, 1'b0, 1'b0, 8'h00);
    fetch(12'h123, 1'b1, 1'b1, 8'hA5);
    chk("arb_mem", mem[12'h123], 8'h3C);
    fetch(12'h123, 1'b1, 1'b0, 8'h3C);

    // stray sync in M2
    repeat (4) tick;
    chk("se_ph_m2", phase, 4);
    chk("se_pre", sync_err, 0);
    sync = 1'b1;
    tick;
    sync = 1'b0;
    #1;
    chk("se_ph", phase, 0);
    chk("se_err", sync_err, 1);
    repeat (3) tick;
    chk("se_sticky", sync_err, 1);
    chk("se_ph2", phase, 3);
    repeat (4) tick;
    sync = 1'b1;
    tick;
    sync = 1'b0;
    chk("se_sticky2", sync_err, 1);

    // reset during M1 of a live fetch
    dbus_in = 4'h3;
    tick;
    dbus_in = 4'h2;
    tick;
    dbus_in = 4'h1;
    cm_rom = 1'b1;
    tick;
    cm_rom = 1'b0;
    #1;
    chk("rm_oe", dbus_oe, 1);
    rst = 1'b1;
    host_valid = 1'b1;
    host_addr = 12'h200;
    host_data = 8'h77;
    #1;
    chk("rm_rdy", host_ready, 0);
    chk("rm_en", mem_en, 0);
    tick;
    rst = 1'b0;
    host_valid = 1'b0;
    #1;
    chk("rm_oe2", dbus_oe, 0);
    chk("rm_lock", locked, 0);
    chk("rm_err", sync_err, 0);
    seen = 0;
    cm_rom = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dbus_in = i[3:0];
      #1;
      if (mem_en || dbus_oe) seen++;
      tick;
    end
    cm_rom = 1'b0;
    chk("rm_nofetch", seen, 0);
    chk("rm_nowr", mem[12'h200], 8'h00);

    lock();
    fetch(12'h000, 1'b1, 1'b0, 8'h5A);
    fetch(12'h001, 1'b1, 1'b0, 8'hC3);
    fetch(12'hFFF, 1'b1, 1'b0, 8'h96);
`ifdef MCS4_ROM_TRACE_EN
    chk("tr_cnt", fetch_count, 3);
    chk("tr_fa", fetch_addr, 12'hFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
